alpha_update_controller: RTL

//  Sequences run-time coefficient updates for the one-pole variable low-pass filter.

---
 rtl/alpha_update_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alpha_update_controller.sv
// Coefficient update sequencer for the one-pole low-pass filter: alpha = 2*pi*fc / (fs + 2*pi*fc).
// Optional macro ALPHA_SLEW_EN limits alpha_out movement to SLEW_STEP per sample strobe.
module alpha_update_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 8,
  parameter int TWO_PI_Q    = 1608,
  parameter int ALPHA_RESET = 0,
  parameter int SLEW_STEP   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_fs,
  input  logic [DATA_WIDTH-1:0] req_fc,
  input  logic                  sample_strobe,
  output logic [FRAC_WIDTH-1:0] alpha_out,
  output logic                  alpha_valid,
  output logic                  busy,
  output logic                  div_err
);

  localparam int NW  = DATA_WIDTH + FRAC_WIDTH + 3;
  localparam int DDW = DATA_WIDTH + FRAC_WIDTH + 4;
  localparam int RW  = DDW + 1;
  localparam int QW  = FRAC_WIDTH + 1;
  localparam int CW  = $clog2(QW + 1);
`ifdef ALPHA_SLEW_EN
  localparam logic [FRAC_WIDTH:0] STEP = (FRAC_WIDTH+1)'(SLEW_STEP);
`else
  localparam logic [FRAC_WIDTH:0] STEP = (FRAC_WIDTH+1)'(2 ** FRAC_WIDTH);
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DIV, PEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] fs_q, fs_d, fc_q, fc_d;
  logic [DDW-1:0]        den_q, den_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FRAC_WIDTH-1:0] alpha_q, alpha_d;
  logic                  alpha_valid_q, alpha_valid_d;
  logic                  div_err_q, div_err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;

  logic [NW-1:0]         num;
  logic [DDW-1:0]        den_calc;
  logic [RW-1:0]         trial;
  logic                  ge;
  logic [FRAC_WIDTH-1:0] target;
  logic [FRAC_WIDTH:0]   diff;

  always_comb begin
    state_d       = state_q;
    fs_d          = fs_q;
    fc_d          = fc_q;
    den_d         = den_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    alpha_d       = alpha_q;
    alpha_valid_d = 1'b0;
    div_err_d     = div_err_q;
    diff          = '0;

    num      = NW'(TWO_PI_Q) * {{(NW-DATA_WIDTH){1'b0}}, fc_q};
    den_calc = ({{(DDW-DATA_WIDTH){1'b0}}, fs_q} << FRAC_WIDTH) + {1'b0, num};
    // First iteration tests N against D unshifted; later ones shift in a zero bit.
    trial    = (cnt_q == '0) ? rem_q : (rem_q << 1);
    ge       = (trial >= {1'b0, den_q});
    target   = quo_q[QW-1] ? {FRAC_WIDTH{1'b1}} : quo_q[FRAC_WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          fs_d      = req_fs;
          fc_d      = req_fc;
          div_err_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        den_d = den_calc;
        rem_d = {{(RW-NW){1'b0}}, num};
        quo_d = '0;
        cnt_d = '0;
        if (den_calc == '0) begin
          div_err_d = 1'b1;
          state_d   = PEND;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = ge ? (trial - {1'b0, den_q}) : trial;
        quo_d = {quo_q[QW-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QW - 1)) state_d = PEND;
      end
      PEND: begin
        if (sample_strobe) begin
          if (target > alpha_q) begin
            diff = {1'b0, target} - {1'b0, alpha_q};
            if (diff <= STEP) begin
              alpha_d       = target;
              alpha_valid_d = 1'b1;
              state_d       = IDLE;
            end else begin
              alpha_d = alpha_q + STEP[FRAC_WIDTH-1:0];
            end
          end else if (target < alpha_q) begin
            diff = {1'b0, alpha_q} - {1'b0, target};
            if (diff <= STEP) begin
              alpha_d       = target;
              alpha_valid_d = 1'b1;
              state_d       = IDLE;
            end else begin
              alpha_d = alpha_q - STEP[FRAC_WIDTH-1:0];
            end
          end else begin
            alpha_valid_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fs_q          <= '0;
      fc_q          <= '0;
      den_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      alpha_q       <= FRAC_WIDTH'(ALPHA_RESET);
      alpha_valid_q <= 1'b0;
      div_err_q     <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fs_q          <= fs_d;
      fc_q          <= fc_d;
      den_q         <= den_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      alpha_q       <= alpha_d;
      alpha_valid_q <= alpha_valid_d;
      div_err_q     <= div_err_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign alpha_out   = alpha_q;
  assign alpha_valid = alpha_valid_q;
  assign div_err     = div_err_q;
  assign req_ready   = req_ready_q;
  assign busy        = busy_q;

endmodule
